// File: rtl/hand_disp_scheduler.sv
// Frame-synchronous hand-position scheduler: buffers one tracker sample, scales it on vsync fall, commits atomically.
// Optional build macro HAND_STALE_TIMEOUT_EN adds a stale-frame timeout on hands_valid.
module hand_disp_scheduler #(
  parameter int MIN_Z_DEAD_ZONE = 800,
  parameter int MAX_Z_DEAD_ZONE = 1050,
  parameter int STALE_FRAMES    = 32
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic [15:0] z1,
  input  logic [15:0] x2,
  input  logic [15:0] y2,
  input  logic [15:0] z2,
  output logic [15:0] x1_disp,
  output logic [15:0] y1_disp,
  output logic [15:0] x2_disp,
  output logic [15:0] y2_disp,
  output logic [1:0]  left_zone,
  output logic [1:0]  right_zone,
  output logic        frame_done,
  output logic        busy,
  output logic        hands_valid
);

  typedef enum logic [1:0] {IDLE, SCALE, COMMIT} state_t;

  localparam logic [15:0] MIN_Z = 16'(MIN_Z_DEAD_ZONE);
  localparam logic [15:0] MAX_Z = 16'(MAX_Z_DEAD_ZONE);

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic        pending_q;
  logic        vsync_d_q;
  logic        committed_q;
  logic [15:0] shadow_q [6];   // x1, y1, x2, y2, z1, z2
  logic [15:0] stage_q  [4];
  logic [15:0] disp_q   [4];
  logic [1:0]  lzone_q, rzone_q;
  logic        vsync_fall;
  logic        accept;
  logic [15:0] scale_out;

  function automatic logic [1:0] zone_of(input logic [15:0] z);
    if (z < MIN_Z)       return 2'd0;
    else if (z >= MAX_Z) return 2'd2;
    else                 return 2'd1;
  endfunction

  assign s_ready    = !pending_q;
  assign accept     = s_valid && s_ready;
  assign vsync_fall = vsync_d_q && !vsync;
  // Single shared scaler; the product is kept in 16-bit context so it truncates naturally.
  assign scale_out  = (shadow_q[idx_q] >> 1) * 16'd3;

  // State register and control/output registers.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      pending_q   <= 1'b0;
      vsync_d_q   <= 1'b1;
      committed_q <= 1'b0;
      lzone_q     <= 2'd0;
      rzone_q     <= 2'd0;
      for (int i = 0; i < 4; i++) disp_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vsync_d_q <= vsync;
      idx_q     <= (state_q == SCALE) ? idx_q + 2'd1 : 2'd0;
      if (state_q == COMMIT) begin
        pending_q   <= 1'b0;
        committed_q <= 1'b1;
        lzone_q     <= zone_of(shadow_q[4]);
        rzone_q     <= zone_of(shadow_q[5]);
        for (int i = 0; i < 4; i++) disp_q[i] <= stage_q[i];
      end else if (accept) begin
        pending_q <= 1'b1;
      end
    end
  end

  // NOTE: shadow and staging are always qualified by pending/state, so they carry no reset.
  always_ff @(posedge vclock) begin
    if (accept) begin
      shadow_q[0] <= x1;
      shadow_q[1] <= y1;
      shadow_q[2] <= x2;
      shadow_q[3] <= y2;
      shadow_q[4] <= z1;
      shadow_q[5] <= z2;
    end
    if (state_q == SCALE) stage_q[idx_q] <= scale_out;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (vsync_fall && pending_q) state_d = SCALE;
      SCALE:   if (idx_q == 2'd3)           state_d = COMMIT;
      COMMIT:                               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state_q)
      SCALE:   busy = 1'b1;
      COMMIT:  begin busy = 1'b1; frame_done = 1'b1; end
      default: ;
    endcase
  end

`ifdef HAND_STALE_TIMEOUT_EN
  localparam int SW = $clog2(STALE_FRAMES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);
  logic [SW-1:0] stale_q;

  // Counts frames that arrived with nothing new to show; saturates at the limit.
  always_ff @(posedge vclock) begin
    if (reset)                                            stale_q <= '0;
    else if (state_q == COMMIT)                           stale_q <= '0;
    else if (vsync_fall && !pending_q && stale_q != STALE_MAX) stale_q <= stale_q + SW'(1);
  end

  assign hands_valid = committed_q && (stale_q < STALE_MAX);
`else
  assign hands_valid = committed_q;
`endif

  assign x1_disp    = disp_q[0];
  assign y1_disp    = disp_q[1];
  assign x2_disp    = disp_q[2];
  assign y2_disp    = disp_q[3];
  assign left_zone  = lzone_q;
  assign right_zone = rzone_q;

endmodule

// File: tb/tb_hand_disp_scheduler.sv
// Scoreboard bench for hand_disp_scheduler: stimulus pushes expected commits, a monitor checks each frame_done.
module tb_hand_disp_scheduler;

  logic        vclock = 1'b0;
  logic        reset, vsync, s_valid, s_ready;
  logic [15:0] x1, y1, z1, x2, y2, z2;
  logic [15:0] x1_disp, y1_disp, x2_disp, y2_disp;
  logic [1:0]  left_zone, right_zone;
  logic        frame_done, busy, hands_valid;

  hand_disp_scheduler dut (
    .vclock(vclock), .reset(reset), .vsync(vsync), .s_valid(s_valid), .s_ready(s_ready),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .x1_disp(x1_disp), .y1_disp(y1_disp), .x2_disp(x2_disp), .y2_disp(y2_disp),
    .left_zone(left_zone), .right_zone(right_zone),
    .frame_done(frame_done), .busy(busy), .hands_valid(hands_valid)
  );

  always #5 vclock = ~vclock;

  int cyc = 0;
  always @(posedge vclock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x1d, y1d, x2d, y2d;
    logic [1:0]  lz, rz;
    int          edge_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [15:0] a, b, c, d, input logic [1:0] l, r);
    exp_t e;
    e.x1d = a; e.y1d = b; e.x2d = c; e.y2d = d; e.lz = l; e.rz = r; e.edge_cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge vclock);
    #1;
  endtask

  task automatic offer(input logic [15:0] a, b, c, d, e, f, input logic exp_ready);
    x1 = a; y1 = b; z1 = c; x2 = d; y2 = e; z2 = f;
    s_valid = 1'b1;
    check("s_ready_on_offer", s_ready, exp_ready);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic vfall(input bit commit, input exp_t e);
    exp_t t;
    t = e;
    vsync = 1'b0;
    if (commit) begin
      t.edge_cyc = cyc;
      sb.push_back(t);
    end
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 0);
    tick(3);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_x1_disp"}, x1_disp, 0);
    check({tag, "_y1_disp"}, y1_disp, 0);
    check({tag, "_x2_disp"}, x2_disp, 0);
    check({tag, "_y2_disp"}, y2_disp, 0);
    check({tag, "_zones"}, {left_zone, right_zone}, 0);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hands_valid"}, hands_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Monitor: every frame_done must match the next scoreboard entry, outputs appear one cycle later.
  initial begin
    forever begin
      @(negedge vclock);
      if (!reset && frame_done) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("commit_latency", cyc - mon_e.edge_cyc, 5);
          @(negedge vclock);
          check("frame_done_width", frame_done, 0);
          check("x1_disp", x1_disp, mon_e.x1d);
          check("y1_disp", y1_disp, mon_e.y1d);
          check("x2_disp", x2_disp, mon_e.x2d);
          check("y2_disp", y2_disp, mon_e.y2d);
          check("left_zone", left_zone, mon_e.lz);
          check("right_zone", right_zone, mon_e.rz);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; vsync = 1'b1; s_valid = 1'b0;
    x1 = '0; y1 = '0; z1 = '0; x2 = '0; y2 = '0; z2 = '0;
    tick(3);
    reset = 1'b0;
    check_zero_outputs("reset");

    // Single update with near/far zones.
    offer(100, 200, 700, 650, 460, 1050, 1'b1);
    check("s_ready_after_accept", s_ready, 0);
    vfall(1'b1, mk(150, 300, 975, 690, 2'd0, 2'd2));
    check("busy_in_scale", busy, 1);
    drain();
    check("hands_valid_after_commit", hands_valid, 1);
    check("s_ready_after_commit", s_ready, 1);

    // Backpressure: second sample while pending is dropped.
    offer(10, 20, 900, 30, 40, 1049, 1'b1);
    offer(999, 999, 2000, 999, 999, 0, 1'b0);
    vfall(1'b1, mk(15, 30, 45, 60, 2'd1, 2'd1));
    drain();

    // Accept and vsync edge in the same cycle: held until the next edge.
    x1 = 2; y1 = 4; z1 = 800; x2 = 6; y2 = 8; z2 = 799;
    s_valid = 1'b1; vsync = 1'b0;
    tick();
    s_valid = 1'b0; vsync = 1'b1;
    tick(10);
    check("simul_hold_x1_disp", x1_disp, 15);
    check("simul_pending", s_ready, 0);
    vfall(1'b1, mk(3, 6, 9, 12, 2'd1, 2'd0));
    drain();

    // Reset during the second SCALE cycle aborts without committing.
    offer(40, 80, 800, 120, 160, 2000, 1'b1);
    vfall(1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0));
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero_outputs("abort");
    tick(10);
    vfall(1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0));
    tick(8);
    check("abort_no_commit_x2_disp", x2_disp, 0);

    // Odd coordinates, truncation and z boundaries.
    offer(101, 65535, 799, 1, 3, 800, 1'b1);
    vfall(1'b1, mk(150, 32765, 0, 3, 2'd0, 2'd1));
    drain();
    offer(0, 0, 1049, 7, 2, 65535, 1'b1);
    vfall(1'b1, mk(0, 0, 9, 3, 2'd1, 2'd2));
    drain();

`ifdef HAND_STALE_TIMEOUT_EN
    for (int i = 1; i <= 32; i++) begin
      vfall(1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0));
      if (i >= 31) check("stale_hands_valid", hands_valid, (i < 32) ? 1 : 0);
    end
    offer(20, 40, 900, 60, 80, 900, 1'b1);
    vfall(1'b1, mk(30, 60, 90, 120, 2'd1, 2'd1));
    drain();
    check("stale_restored", hands_valid, 1);
`else
    for (int i = 0; i < 40; i++) vfall(1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0));
    check("hands_valid_persistent", hands_valid, 1);
    check("idle_edges_keep_x1_disp", x1_disp, 0);
    check("idle_edges_keep_x2_disp", x2_disp, 9);
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
